// File: rtl/osd_pkg.sv
// osd_pkg: shared state encoding and OSD command opcodes for the OSD io sequencer
package osd_pkg;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STB,
    GAP,
    WAIT,
    TAIL,
    DISCARD
  } osd_state_t;
  localparam logic [7:0] OSD_CMD_WRITE       = 8'h20;
  localparam logic [7:0] OSD_CMD_ENABLE      = 8'h40;
  localparam logic [7:0] OSD_CMD_MASK_WRITE  = 8'hE0;
  localparam logic [7:0] OSD_CMD_MASK_ENABLE = 8'hF0;
endpackage

// File: rtl/osd_seq_fifo.sv
// osd_seq_fifo: first-word-fall-through FIFO of {last, data} words with async reset
module osd_seq_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign dout  = mem[rp[AW-1:0]];
  // storage write; the head is read combinationally so it falls through
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  // pointers carry an extra wrap bit to tell full from empty
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
endmodule

// File: rtl/osd_io_sequencer.sv
// osd_io_sequencer: serialises OSD command packets onto io_osd/io_strobe/io_din; OSD_SEQ_TIMEOUT_EN adds stall abort
module osd_io_sequencer
  import osd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int SETUP_CYC  = 2,
  parameter int STB_CYC    = 1,
  parameter int GAP_CYC    = 1,
  parameter int IDLE_CYC   = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy,
  output logic        abort_pulse
);
  if (FIFO_DEPTH < 4 || SETUP_CYC < 1 || STB_CYC < 1 || GAP_CYC < 1 || IDLE_CYC < 1 || TIMEOUT < 2) begin : g_bad_param
    $error("osd_io_sequencer: parameter out of range");
  end
  osd_state_t state, state_n;
  logic [3:0] cnt, cnt_n, idle_cnt, idle_n;
  logic [15:0] din_n;
  logic [16:0] head;
  logic last_r, last_n, osd_n, stb_n, busy_n, rdy, push, pop, full, empty;
  assign s_ready = rdy & (~full | pop);
  assign push = s_valid & s_ready;
  osd_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(17)) u_fifo (
    .clk(clk_sys), .reset(reset), .push(push), .pop(pop),
    .din({s_last, s_data}), .dout(head), .full(full), .empty(empty)
  );
`ifdef OSD_SEQ_TIMEOUT_EN
  logic [12:0] stall;
  logic abort_n;
  // stall timer only runs while starved mid-packet
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) stall <= '0;
    else stall <= (state == WAIT) ? stall + 13'd1 : '0;
`else
  assign abort_pulse = 1'b0;
`endif
  // next-state and next-output logic; io_din is loaded one cycle before each strobe rises
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_n = last_r;
    osd_n = io_osd;
    din_n = io_din;
    pop = 1'b0;
    stb_n = state == STB;
    idle_n = (!io_osd && idle_cnt != 4'hf) ? idle_cnt + 4'd1 : idle_cnt;
`ifdef OSD_SEQ_TIMEOUT_EN
    abort_n = 1'b0;
`endif
    case (state)
      IDLE:
        if (!empty && idle_cnt >= 4'(IDLE_CYC)) begin
          osd_n = 1'b1;
          din_n = head[15:0];
          state_n = (SETUP_CYC == 1) ? STB : SETUP;
          cnt_n = (SETUP_CYC == 1) ? 4'(STB_CYC - 1) : 4'(SETUP_CYC - 2);
        end
      SETUP:
        if (cnt == 4'd0) begin
          state_n = STB;
          cnt_n = 4'(STB_CYC - 1);
        end else cnt_n = cnt - 4'd1;
      STB:
        if (cnt == 4'd0) begin
          pop = 1'b1;
          last_n = head[16];
          state_n = GAP;
          cnt_n = 4'(GAP_CYC - 1);
        end else cnt_n = cnt - 4'd1;
      GAP:
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else if (last_r) state_n = TAIL;
        else if (!empty) begin
          state_n = STB;
          din_n = head[15:0];
          cnt_n = 4'(STB_CYC - 1);
        end else state_n = WAIT;
      WAIT:
        if (!empty) begin
          state_n = STB;
          din_n = head[15:0];
          cnt_n = 4'(STB_CYC - 1);
        end
`ifdef OSD_SEQ_TIMEOUT_EN
        else if (stall == 13'(TIMEOUT - 1)) begin
          state_n = DISCARD;
          osd_n = 1'b0;
          idle_n = 4'd0;
          abort_n = 1'b1;
        end
      DISCARD:
        if (!empty) begin
          pop = 1'b1;
          state_n = head[16] ? IDLE : DISCARD;
        end
`endif
      TAIL: begin
        osd_n = 1'b0;
        idle_n = 4'd0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) | (!empty & !pop) | push;
  end
  // state, counters and registered bus outputs
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idle_cnt <= '0;
      last_r <= 1'b0;
      rdy <= 1'b0;
      io_osd <= 1'b0;
      io_strobe <= 1'b0;
      io_din <= '0;
      busy <= 1'b0;
`ifdef OSD_SEQ_TIMEOUT_EN
      abort_pulse <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idle_cnt <= idle_n;
      last_r <= last_n;
      rdy <= 1'b1;
      io_osd <= osd_n;
      io_strobe <= stb_n;
      io_din <= din_n;
      busy <= busy_n;
`ifdef OSD_SEQ_TIMEOUT_EN
      abort_pulse <= abort_n;
`endif
    end
endmodule

// File: tb/tb_osd_io_sequencer.sv
// tb_osd_io_sequencer: directed bench with a small OSD receiver model for osd_io_sequencer
module tb_osd_io_sequencer;
  import osd_pkg::*;
`ifdef OSD_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 64;
`else
  localparam int TB_TIMEOUT = 4096;
`endif
  logic clk_sys = 1'b0, reset = 1'b1;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic [15:0] s_data = '0;
  logic s_ready, io_osd, io_strobe, busy, abort_pulse;
  logic [15:0] io_din;
  int checks = 0, errors = 0;
  osd_io_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .io_osd(io_osd), .io_strobe(io_strobe),
    .io_din(io_din), .busy(busy), .abort_pulse(abort_pulse)
  );
  always #5 clk_sys = ~clk_sys;

  // OSD receiver model, sampled on the falling edge
  logic prev_osd = 0, prev_stb = 0, osd_enable = 0;
  logic [15:0] prev_din = '0, pkt_cmd = '0, last_word = '0;
  logic [15:0] buffer [256];
  logic [15:0] seen_q [$];
  int strobes = 0, nwords = 0, pre_cnt = 0, setup_seen = 0, stb_len = 0;
  int low_run = 0, min_gap = 99, din_viol = 0, bad_stb = 0, aborts = 0;
  bit seen = 0, saw_full = 0;
  always @(negedge clk_sys) begin
    if (abort_pulse) aborts++;
    if (io_strobe && !io_osd) din_viol++;
    if (io_strobe && prev_stb && io_din != prev_din) din_viol++;
    if (io_osd && !prev_osd) begin
      if (seen && low_run < min_gap) min_gap = low_run;
      seen = 1;
      pre_cnt = 0;
      nwords = 0;
    end
    if (!io_osd && prev_osd) begin
      low_run = 0;
      if (pkt_cmd[7:1] == 7'h20 && nwords > 0) osd_enable = pkt_cmd[0];
    end
    if (!io_osd) low_run++;
    if (io_osd && !io_strobe && nwords == 0) pre_cnt++;
    if (!io_strobe && prev_stb && stb_len != 1) bad_stb++;
    if (io_strobe && !prev_stb) begin
      if (io_din != prev_din) din_viol++;
      strobes++;
      last_word = io_din;
      seen_q.push_back(io_din);
      if (nwords == 0) begin
        pkt_cmd = io_din;
        setup_seen = pre_cnt;
      end else if (pkt_cmd[7:0] == OSD_CMD_WRITE && nwords <= 256) buffer[nwords-1] = io_din;
      nwords++;
      stb_len = 0;
    end
    if (io_strobe) stb_len++;
    prev_osd = io_osd;
    prev_stb = io_strobe;
    prev_din = io_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // called on a falling edge; returns on the falling edge after the word is taken
  task automatic push_word(input logic [15:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    while (!s_ready && n < 1000) begin
      saw_full = 1;
      @(negedge clk_sys);
      n++;
    end
    if (n >= 1000) check("push_timeout", 0, 1);
    @(negedge clk_sys);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 5000) check("idle_timeout", 0, 1);
    repeat (4) @(negedge clk_sys);
  endtask

  int s0;
  logic [15:0] exp_q [$];
  initial begin
    // reset held with a word offered
    s_valid = 1'b1;
    s_data = 16'h0041;
    s_last = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rst_ready", s_ready, 0);
    check("rst_osd", io_osd, 0);
    check("rst_strobe", io_strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_din", io_din, 0);
    check("rst_abort", abort_pulse, 0);
    reset = 1'b0;
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("rst_no_word", strobes, 0);
    check("rst_idle_busy", busy, 0);
    check("rst_ready_after", s_ready, 1);

    // single enable packet
    push_word({8'h00, OSD_CMD_ENABLE} | 16'h0001, 1'b1);
    wait_idle();
    check("en_strobes", strobes, 1);
    check("en_setup", setup_seen, 2);
    check("en_word", last_word, 16'h0041);
    check("en_enable", osd_enable, 1);
    check("en_osd_low", io_osd, 0);

    // 257-word row write
    s0 = strobes;
    push_word({8'h00, OSD_CMD_WRITE}, 1'b0);
    for (int i = 0; i < 256; i++) push_word(16'((i * 7 + 3) & 8'hff), i == 255);
    wait_idle();
    check("row_strobes", strobes - s0, 257);
    for (int i = 0; i < 256; i++) check("row_buf", buffer[i], 32'((i * 7 + 3) & 8'hff));
    check("row_gap", min_gap >= 2, 1);

    // mid-packet starvation
    s0 = strobes;
    push_word({8'h00, OSD_CMD_WRITE}, 1'b0);
    for (int i = 1; i <= 3; i++) push_word(16'h0100 + 16'(i), 1'b0);
    repeat (50) @(negedge clk_sys);
    check("starve_osd", io_osd, 1);
    check("starve_strobe", io_strobe, 0);
    check("starve_cnt", strobes - s0, 4);
    push_word(16'h0104, 1'b0);
    push_word(16'h0105, 1'b1);
    wait_idle();
    check("starve_total", strobes - s0, 6);
    check("starve_buf0", buffer[0], 16'h0101);
    check("starve_buf4", buffer[4], 16'h0105);

    // two 20-word packets back-to-back fill the FIFO
    s0 = strobes;
    saw_full = 0;
    seen_q.delete();
    exp_q.delete();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 20; i++) exp_q.push_back(i == 0 ? {8'h00, OSD_CMD_WRITE} : 16'h1000 * 16'(p + 1) + 16'(i));
    for (int i = 0; i < 40; i++) push_word(exp_q[i], i == 19 || i == 39);
    wait_idle();
    check("full_seen", saw_full, 1);
    check("full_strobes", strobes - s0, 40);
    check("full_count", seen_q.size(), 40);
    for (int i = 0; i < 40 && i < seen_q.size(); i++) check("full_word", seen_q[i], exp_q[i]);
    check("pkt_gap", min_gap >= 2, 1);

`ifdef OSD_SEQ_TIMEOUT_EN
    // stalled packet is aborted and its remaining words discarded
    begin
      int n = 0;
      s0 = strobes;
      push_word({8'h00, OSD_CMD_WRITE}, 1'b0);
      push_word(16'h00a1, 1'b0);
      push_word(16'h00a2, 1'b0);
      while (aborts == 0 && n < 300) begin
        @(negedge clk_sys);
        n++;
      end
      check("to_abort_seen", aborts, 1);
      check("to_pre_strobes", strobes - s0, 3);
      check("to_osd_low", io_osd, 0);
      s0 = strobes;
      for (int i = 0; i < 4; i++) push_word(16'h00b1 + 16'(i), i == 3);
      push_word({8'h00, OSD_CMD_ENABLE}, 1'b1);
      wait_idle();
      check("to_abort_once", aborts, 1);
      check("to_post_strobes", strobes - s0, 1);
      check("to_post_word", last_word, 16'h0040);
      check("to_enable", osd_enable, 0);
    end
`endif

    // reset in the middle of a packet
    begin
      int n = 0;
      push_word({8'h00, OSD_CMD_WRITE}, 1'b0);
      for (int i = 0; i < 8; i++) push_word(16'h0200 + 16'(i), i == 7);
      while (!io_strobe && n < 100) begin
        @(negedge clk_sys);
        n++;
      end
      reset = 1'b1;
      #1;
      check("mid_rst_osd", io_osd, 0);
      check("mid_rst_strobe", io_strobe, 0);
      check("mid_rst_ready", s_ready, 0);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      s0 = strobes;
      repeat (20) @(negedge clk_sys);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_quiet", strobes - s0, 0);
    end

    check("din_stable", din_viol, 0);
    check("stb_width", bad_stb, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
